// File: rtl/stack_frame_store.sv
// Call-frame store for the MiniRISC stack protocol.
// Each request runs for four fixed cycles, and the acknowledge comes in the last one.
module stack_frame_store #(
  parameter int DEPTH  = 16,
  parameter int PC_W   = 8,
  parameter int FLAG_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stack_op_start,
  input  logic              push_or_pop,
  input  logic [PC_W-1:0]   data_in_PC,
  input  logic [FLAG_W-1:0] data_in_flags,
  output logic              stack_op_end,
  output logic [PC_W-1:0]   data_out_PC,
  output logic [FLAG_W-1:0] data_out_flags,
  output logic [7:0]        SP,
  output logic              busy,
  output logic              empty,
  output logic              full,
  output logic              ovf_err,
  output logic              unf_err
);

  localparam int WORDS = 2 * DEPTH;
  localparam int AW    = $clog2(WORDS);
  localparam logic [7:0] SP_FULL = 8'(WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH_PC, S_PUSH_FL, S_POP_FL, S_POP_PC, S_DONE
  } state_t;

  state_t            r_state;
  logic [7:0]        r_sp;
  logic              r_refuse;
  logic [PC_W-1:0]   r_pc;
  logic [FLAG_W-1:0] r_fl;
  logic              r_end;
  logic              r_ovf;
  logic              r_unf;
  logic [PC_W-1:0]   r_out_pc;
  logic [FLAG_W-1:0] r_out_fl;
  logic [7:0]        r_mem [WORDS];

  logic              w_empty;
  logic              w_full;
  logic              w_wr_en;
  logic [AW-1:0]     w_wr_addr;
  logic [AW-1:0]     w_rd_addr;
  logic [7:0]        w_wr_data;

  assign w_empty = (r_sp == 8'd0);
  assign w_full  = (r_sp == SP_FULL);

  // The PC word sits at SP and the flags word at SP+1, so a pop reads flags first.
  always_comb begin
    w_wr_en   = !r_refuse && ((r_state == S_PUSH_PC) || (r_state == S_PUSH_FL));
    w_wr_addr = AW'(r_sp) + ((r_state == S_PUSH_FL) ? AW'(1) : AW'(0));
    w_wr_data = (r_state == S_PUSH_FL) ? 8'(r_fl) : 8'(r_pc);
    w_rd_addr = AW'(r_sp) - ((r_state == S_POP_FL) ? AW'(1) : AW'(2));
  end

  // NOTE: the frame array has no reset; stale words are unreachable because SP returns to 0.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
  end

  // NOTE: every register here uses <= so all updates see pre-edge values of r_sp and r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sp     <= 8'd0;
      r_refuse <= 1'b0;
      r_pc     <= '0;
      r_fl     <= '0;
      r_end    <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_out_pc <= '0;
      r_out_fl <= '0;
    end else begin
      r_end <= 1'b0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (stack_op_start) begin
            r_pc     <= data_in_PC;
            r_fl     <= data_in_flags;
            r_refuse <= push_or_pop ? w_empty : w_full;
            r_state  <= push_or_pop ? S_POP_FL : S_PUSH_PC;
          end
        end
        S_PUSH_PC: r_state <= S_PUSH_FL;
        S_PUSH_FL: begin
          if (!r_refuse) r_sp <= r_sp + 8'd2;
          r_end   <= 1'b1;
          r_ovf   <= r_refuse;
          r_state <= S_DONE;
        end
        S_POP_FL: begin
          if (!r_refuse) r_out_fl <= r_mem[w_rd_addr][FLAG_W-1:0];
          r_state <= S_POP_PC;
        end
        S_POP_PC: begin
          if (!r_refuse) begin
            r_out_pc <= r_mem[w_rd_addr][PC_W-1:0];
            r_sp     <= r_sp - 8'd2;
          end
          r_end   <= 1'b1;
          r_unf   <= r_refuse;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stack_op_end   = r_end;
  assign ovf_err        = r_ovf;
  assign unf_err        = r_unf;
  assign data_out_PC    = r_out_pc;
  assign data_out_flags = r_out_fl;
  assign SP             = r_sp;
  assign busy           = (r_state != S_IDLE);
  assign empty          = w_empty;
  assign full           = w_full;

endmodule
